// File: rtl/instrumented_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instrumented_adder_pkg
// Brief   : Shared FSM state type and default sizing for the ring measurement
// Revision: 1.0
// ============================================================================
package instrumented_adder_pkg;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_COUNT_W = 24;
    localparam int DEF_WIN_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ring_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : ring_edge_sync
// Brief   : Two-flop synchroniser for one ring tap plus a rising-edge pulse
// Revision: 1.0
// ============================================================================
module ring_edge_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ring_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= ring_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/instrumented_adder_measure.sv
`default_nettype none
// ============================================================================
// Module  : instrumented_adder_measure
// Brief   : Counts rising edges of a selected ring-oscillator tap over a window
// Revision: 1.0
// ============================================================================
module instrumented_adder_measure
    import instrumented_adder_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int WIN_W   = DEF_WIN_W
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n,
    input  logic                      start,
    input  logic [$clog2(NUM_CH)-1:0] chan_sel,
    input  logic [WIN_W-1:0]          window,
    input  logic [NUM_CH-1:0]         ring_in,
    output logic [COUNT_W-1:0]        count,
    output logic                      overflow,
    output logic                      busy,
    output logic                      done
);

    localparam int SEL_W = $clog2(NUM_CH);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WIN_W-1:0]   rem_q, rem_d;
    logic               arm_q, arm_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [NUM_CH-1:0]  rise;
    logic               sel_rise;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        ring_edge_sync u_sync (
            .clk_i   (wb_clk_i),
            .rst_n_i (wb_rst_n),
            .ring_i  (ring_in[g]),
            .rise_o  (rise[g])
        );
    end

    assign sel_rise = rise[sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        win_d   = win_q;
        rem_d   = rem_q;
        arm_d   = arm_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ARM;
                    sel_d   = chan_sel;
                    win_d   = window;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    arm_d   = 1'b0;
                end
            end
            ST_ARM: begin
                // Two-cycle settle; the remaining-cycle counter is preloaded here
                arm_d = 1'b1;
                rem_d = win_q;
                if (arm_q) begin
                    state_d = (win_q == '0) ? ST_DONE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                rem_d = rem_q - WIN_W'(1);
                if (sel_rise) begin
                    if (&count_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + COUNT_W'(1);
                    end
                end
                if (rem_q == WIN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            win_q   <= '0;
            rem_q   <= '0;
            arm_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            win_q   <= win_d;
            rem_q   <= rem_d;
            arm_q   <= arm_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == ST_ARM) || (state_q == ST_COUNT);
    assign done     = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instrumented_adder_measure.sv
`default_nettype none
// ============================================================================
// Module  : tb_instrumented_adder_measure
// Brief   : Directed self-checking bench with an expected-result scoreboard
// Revision: 1.0
// ============================================================================
module tb_instrumented_adder_measure;

    logic        clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  chan_sel = 2'd0;
    logic [15:0] window = 16'd0;
    logic [3:0]  ring_in = 4'd0;
    logic [23:0] count;
    logic        overflow, busy, done;
    logic [3:0]  count4;
    logic        overflow4, busy4, done4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    cnt;
        int    tol;
        bit    ovf;
        bit    chk4;
        int    cnt4;
        bit    ovf4;
        int    lat;
    } exp_t;
    exp_t sb[$];

    int ring_half [4] = '{0, 0, 0, 0};
    int ring_ph   [4] = '{0, 0, 0, 0};

    instrumented_adder_measure dut (
        .wb_clk_i (clk), .wb_rst_n (wb_rst_n), .start (start),
        .chan_sel (chan_sel), .window (window), .ring_in (ring_in),
        .count (count), .overflow (overflow), .busy (busy), .done (done)
    );

    instrumented_adder_measure #(.COUNT_W(4)) dut4 (
        .wb_clk_i (clk), .wb_rst_n (wb_rst_n), .start (start),
        .chan_sel (chan_sel), .window (window), .ring_in (ring_in),
        .count (count4), .overflow (overflow4), .busy (busy4), .done (done4)
    );

    always #5 clk = ~clk;

    // Ring taps toggle on the falling clock edge with a per-channel half period
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (ring_half[c] != 0) begin
                ring_ph[c]++;
                if (ring_ph[c] >= ring_half[c]) begin
                    ring_ph[c] = 0;
                    ring_in[c] = ~ring_in[c];
                end
            end
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic measure(input string tag, input int sel, input int win,
                           input int ecnt, input int tol, input bit eovf,
                           input bit chk4, input int ecnt4, input bit eovf4,
                           input int repulse_at);
        exp_t e;
        int   lat;
        e.tag = tag; e.cnt = ecnt; e.tol = tol; e.ovf = eovf;
        e.chk4 = chk4; e.cnt4 = ecnt4; e.ovf4 = eovf4; e.lat = win + 2;
        sb.push_back(e);
        @(negedge clk);
        chan_sel = sel[1:0];
        window   = win[15:0];
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_clr_cnt"}, longint'(count), 0);
        check({tag, "_clr_ovf"}, longint'(overflow), 0);
        check({tag, "_clr_ovf4"}, longint'(overflow4), 0);
        check({tag, "_busy0"}, longint'(busy), 1);
        lat = -1;
        for (int k = 1; k <= win + 20; k++) begin
            @(posedge clk); #1;
            start = (k == repulse_at);
            if (k == 1) check({tag, "_busy1"}, longint'(busy), 1);
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_latency"}, lat, e.lat);
        check_rng({e.tag, "_count"}, int'(count), e.cnt - e.tol, e.cnt + e.tol);
        check({e.tag, "_ovf"}, longint'(overflow), longint'(e.ovf));
        check({e.tag, "_done4"}, longint'(done4), 1);
        if (e.chk4) begin
            check({e.tag, "_count4"}, longint'(count4), e.cnt4);
            check({e.tag, "_ovf4"}, longint'(overflow4), longint'(e.ovf4));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", longint'(count), 0);
        check("rst_ovf", longint'(overflow), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        @(negedge clk);
        wb_rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Tap 1 at period 4 clocks over 100 cycles
        ring_half[1] = 2;
        measure("t_ch1_w100", 1, 100, 25, 1, 1'b0, 1'b0, 0, 1'b0, -1);
        repeat (5) @(posedge clk);
        #1;
        check("hold_done", longint'(done), 1);
        check("hold_busy", longint'(busy), 0);
        check_rng("hold_count", int'(count), 24, 26);

        // Tap 0 at period 2 clocks: 4-bit instance saturates
        ring_half[0] = 1;
        measure("t_sat", 0, 40, 20, 1, 1'b0, 1'b1, 15, 1'b1, -1);

        measure("t_win0", 1, 0, 0, 0, 1'b0, 1'b1, 0, 1'b0, -1);

        ring_half[0] = 0;
        ring_half[1] = 0;
        ring_half[2] = 3;
        measure("t_sel_quiet", 0, 50, 0, 0, 1'b0, 1'b1, 0, 1'b0, -1);

        ring_half[1] = 2;
        measure("t_repulse", 1, 60, 15, 1, 1'b0, 1'b0, 0, 1'b0, 20);

        // Reset mid-COUNT, together with a coincident start
        @(negedge clk);
        chan_sel = 2'd1;
        window   = 16'd50;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("pre_rst_busy", longint'(busy), 1);
        check_rng("pre_rst_count", int'(count), 3, 6);
        wb_rst_n = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        wb_rst_n = 1'b1;
        start    = 1'b0;
        check("abort_count", longint'(count), 0);
        check("abort_ovf", longint'(overflow), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check("abort_count4", longint'(count4), 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", longint'(busy), 0);
        check("idle_done", longint'(done), 0);

        measure("t_after_rst", 1, 40, 10, 1, 1'b0, 1'b1, 10, 1'b0, -1);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
